// File: rtl/serial_eq_if.sv
// Handshake and comparator-cell signal bundle for serial_eq_ctrl.
// slave is the sequencer's view. master is the producer/consumer/cell side.
interface serial_eq_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int CNTW  = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic             cmp_a;
  logic             cmp_b;
  logic             cmp_eq;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic [IDXW-1:0]  mismatch_idx;
  logic [CNTW-1:0]  mismatch_cnt;
  logic             busy;

  modport slave (
    input  in_valid, a_word, b_word, cmp_eq, out_ready,
    output in_ready, cmp_a, cmp_b, out_valid, eq, mismatch_idx, mismatch_cnt, busy
  );

  modport master (
    output in_valid, a_word, b_word, cmp_eq, out_ready,
    input  in_ready, cmp_a, cmp_b, out_valid, eq, mismatch_idx, mismatch_cnt, busy
  );
endinterface

// File: rtl/serial_eq_ctrl.sv
// Bit-serial equality sequencer. It feeds one external XNOR cell LSB-first
// and accumulates the equality flag, the lowest mismatch index and the
// mismatch count.
module serial_eq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 0,
  parameter int IDXW       = $clog2(WIDTH),
  parameter int CNTW       = $clog2(WIDTH + 1)
) (
  input logic         clk,
  input logic         rst,
  serial_eq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDXW-1:0]  idx;
  logic             eq_acc;
  logic [IDXW-1:0]  first;
  logic [CNTW-1:0]  cnt;
  logic             run_last;

  // Leave RUN on the final bit, or on the first mismatch when early exit is enabled.
  always_comb begin
    run_last = (idx == LAST_IDX);
    if ((EARLY_EXIT != 0) && !bus.cmp_eq) begin
      run_last = 1'b1;
    end
  end

  // Sequencer state, operand capture and per-bit accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      idx    <= '0;
      eq_acc <= 1'b1;
      first  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_reg  <= bus.a_word;
            b_reg  <= bus.b_word;
            idx    <= '0;
            eq_acc <= 1'b1;
            first  <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (!bus.cmp_eq) begin
            cnt <= cnt + CNTW'(1);
            if (eq_acc) begin
              first  <= idx;
              eq_acc <= 1'b0;
            end
          end
          // idx stays on the last scanned bit so it never leaves 0..WIDTH-1.
          if (run_last) begin
            state <= S_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == S_IDLE);
  assign bus.out_valid    = (state == S_DONE);
  assign bus.busy         = (state == S_RUN);
  assign bus.cmp_a        = (state == S_RUN) ? a_reg[idx] : 1'b0;
  assign bus.cmp_b        = (state == S_RUN) ? b_reg[idx] : 1'b0;
  assign bus.eq           = eq_acc;
  assign bus.mismatch_idx = first;
  assign bus.mismatch_cnt = cnt;

endmodule

// File: tb/tb_serial_eq_ctrl.sv
// Directed bench for serial_eq_ctrl: one instance scans all bits and one
// exits early. Both are driven from a shared stimulus that is steered by sel.
module tb_serial_eq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a_word = '0;
  logic [7:0] b_word = '0;
  logic       force_mis = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_eq_if #(.WIDTH(8)) if0 ();
  serial_eq_if #(.WIDTH(8)) if1 ();

  serial_eq_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_full (.clk(clk), .rst(rst), .bus(if0));
  serial_eq_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_early (.clk(clk), .rst(rst), .bus(if1));

  // Comparator cell model; force_mis makes the cell report a mismatch.
  assign if0.cmp_eq    = ~(if0.cmp_a ^ if0.cmp_b) & ~force_mis;
  assign if1.cmp_eq    = ~(if1.cmp_a ^ if1.cmp_b) & ~force_mis;
  assign if0.in_valid  = in_valid & ~sel;
  assign if1.in_valid  = in_valid & sel;
  assign if0.out_ready = out_ready & ~sel;
  assign if1.out_ready = out_ready & sel;
  assign if0.a_word    = a_word;
  assign if1.a_word    = a_word;
  assign if0.b_word    = b_word;
  assign if1.b_word    = b_word;

  wire       o_in_ready  = sel ? if1.in_ready     : if0.in_ready;
  wire       o_out_valid = sel ? if1.out_valid    : if0.out_valid;
  wire       o_busy      = sel ? if1.busy         : if0.busy;
  wire       o_cmp_a     = sel ? if1.cmp_a        : if0.cmp_a;
  wire       o_cmp_b     = sel ? if1.cmp_b        : if0.cmp_b;
  wire       o_eq        = sel ? if1.eq           : if0.eq;
  wire [2:0] o_idx       = sel ? if1.mismatch_idx : if0.mismatch_idx;
  wire [3:0] o_cnt       = sel ? if1.mismatch_cnt : if0.mismatch_cnt;

  logic [63:0] tr_a;
  logic [63:0] tr_b;
  int          nrun;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b);
    a_word   = a;
    b_word   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a_word   = '0;
    b_word   = '0;
  endtask

  // Counts cycles until out_valid and records the cell inputs seen while busy.
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n    = 0;
    nrun = 0;
    tr_a = '0;
    tr_b = '0;
    while (!o_out_valid && n < 40) begin
      if (o_busy) begin
        tr_a[nrun] = o_cmp_a;
        tr_b[nrun] = o_cmp_b;
        nrun++;
      end
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic chk_res(input string tag, input logic e, input logic [2:0] i, input logic [3:0] c);
    chk({tag, "_eq"},  64'(o_eq),  64'(e));
    chk({tag, "_idx"}, 64'(o_idx), 64'(i));
    chk({tag, "_cnt"}, 64'(o_cnt), 64'(c));
  endtask

  task automatic handoff(input string tag, input logic e);
    out_ready = 1'b1;
    tick();
    chk({tag, "_ho_in_ready"},  64'(o_in_ready),  64'd1);
    chk({tag, "_ho_out_valid"}, 64'(o_out_valid), 64'd0);
    chk({tag, "_ho_eq_hold"},   64'(o_eq),        64'(e));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  64'(o_in_ready),  64'd1);
    chk({tag, "_out_valid"}, 64'(o_out_valid), 64'd0);
    chk({tag, "_busy"},      64'(o_busy),      64'd0);
    chk({tag, "_cmp_ab"},    64'({o_cmp_a, o_cmp_b}), 64'd0);
    chk_res(tag, 1'b1, 3'd0, 4'd0);
  endtask

  initial begin
    int saw_ov;
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("rst0");
    tick();
    tick();
    rst = 1'b0;

    // Equal words, full scan.
    out_ready = 1'b1;
    start(8'hA5, 8'hA5);
    chk("t1_busy", 64'(o_busy), 64'd1);
    chk("t1_bit0", 64'({o_cmp_a, o_cmp_b}), 64'b11);
    wait_done("t1", 8);
    chk("t1_trace_a", tr_a, 64'hA5);
    chk_res("t1", 1'b1, 3'd0, 4'd0);
    handoff("t1", 1'b1);

    // Single mismatch on the MSB, then every bit mismatching.
    start(8'h80, 8'h00);
    wait_done("t2", 8);
    chk_res("t2", 1'b0, 3'd7, 4'd1);
    handoff("t2", 1'b0);
    start(8'hF0, 8'h0F);
    wait_done("t3", 8);
    chk_res("t3", 1'b0, 3'd0, 4'd8);
    handoff("t3", 1'b0);

    // Early-exit instance.
    sel = 1'b1;
    start(8'h00, 8'h04);
    wait_done("ee1", 3);
    chk("ee1_nrun", 64'(nrun), 64'd3);
    chk("ee1_trace_b", tr_b, 64'h4);
    chk_res("ee1", 1'b0, 3'd2, 4'd1);
    handoff("ee1", 1'b0);
    start(8'hF0, 8'h0F);
    wait_done("ee2", 1);
    chk_res("ee2", 1'b0, 3'd0, 4'd1);
    handoff("ee2", 1'b0);
    start(8'h3C, 8'h3C);
    wait_done("ee3", 8);
    chk_res("ee3", 1'b1, 3'd0, 4'd0);
    handoff("ee3", 1'b1);
    sel = 1'b0;

    // Backpressure in DONE with a new word pair pending.
    out_ready = 1'b0;
    start(8'h12, 8'h12);
    wait_done("bp", 8);
    a_word   = 8'h55;
    b_word   = 8'h54;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_valid", 64'({o_out_valid, o_in_ready}), 64'b10);
      chk("bp_stall_res", 64'({o_eq, o_idx, o_cnt}), 64'({1'b1, 3'd0, 4'd0}));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle", 64'({o_in_ready, o_out_valid}), 64'b10);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", 64'({o_busy, o_in_ready, o_cmp_a, o_cmp_b}), 64'b1010);
    wait_done("bp2", 8);
    chk_res("bp2", 1'b0, 3'd0, 4'd1);
    handoff("bp2", 1'b0);

    // Reset in the middle of a scan.
    start(8'h00, 8'hFF);
    for (int i = 0; i < 4; i++) tick();
    chk("mr_partial", 64'({o_busy, o_cnt}), 64'({1'b1, 4'd4}));
    rst = 1'b1;
    #1;
    chk_reset_vals("mr");
    tick();
    rst = 1'b0;
    saw_ov = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_out_valid) saw_ov++;
    end
    chk("mr_no_valid", 64'(saw_ov), 64'd0);
    start(8'h3C, 8'h3C);
    wait_done("mr2", 8);
    chk_res("mr2", 1'b1, 3'd0, 4'd0);
    handoff("mr2", 1'b1);

    // The cell result, not the operands, decides the verdict.
    start(8'h5A, 8'h5A);
    for (int i = 0; i < 5; i++) tick();
    force_mis = 1'b1;
    tick();
    force_mis = 1'b0;
    wait_done("cell", 2);
    chk_res("cell", 1'b0, 3'd5, 4'd1);
    handoff("cell", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_eq_ctrl.md
# serial_eq_ctrl

Bit-serial equality sequencer that drives one external 1-bit equality cell (XNOR-style, `cmp_eq = ~(cmp_a ^ cmp_b)`). It reduces two WIDTH-bit words to an equality verdict without replicating the cell WIDTH times. Words are accepted over a valid/ready handshake and presented to the cell one bit per clock, LSB first. The per-bit results are accumulated into an equality flag, the index of the lowest mismatching bit, and a mismatch count. The block sits between a word-level producer and the shared 1-bit comparator cell.

## Interface
- WIDTH, 8: word width in bits; legal range 2..64.
- EARLY_EXIT, 0: 1 = stop at the first mismatching bit; 0 = always scan all WIDTH bits.
- IDXW, $clog2(WIDTH): width of the bit index.
- CNTW, $clog2(WIDTH+1): width of the mismatch count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer has a word pair.
- in_ready  out  1  block can accept; equals (state==IDLE).
- a_word  in  WIDTH  operand A; captured on accept.
- b_word  in  WIDTH  operand B; captured on accept.
- cmp_a  out  1  bit to comparator cell, from A.
- cmp_b  out  1  bit to comparator cell, from B.
- cmp_eq  in  1  combinational result from the cell.
- out_valid  out  1  result available; equals (state==DONE).
- out_ready  in  1  consumer takes the result.
- eq  out  1  1 = words equal (all scanned bits matched).
- mismatch_idx  out  IDXW  lowest mismatching bit index; 0 when eq=1.
- mismatch_cnt  out  CNTW  number of mismatching bits scanned.
- busy  out  1  (state==RUN).

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- IDLE → RUN on in_valid && in_ready.
  - a_word and b_word are latched into internal registers.
  - idx is cleared to 0.
  - Accumulators are initialised: eq_acc=1, cnt=0, first=0.
- RUN:
  - cmp_a = A_reg[idx] and cmp_b = B_reg[idx], driven combinationally.
  - On each clock edge, cmp_eq is sampled.
  - If cmp_eq=0: cnt is incremented. If eq_acc=1 at that point, first is set to idx and eq_acc is cleared.
  - idx is incremented.
- RUN → DONE when idx==WIDTH-1 is sampled.
- RUN → DONE also when EARLY_EXIT=1 and the sampled cmp_eq=0.
- DONE:
  - eq, mismatch_idx and mismatch_cnt hold stable.
  - On out_valid && out_ready, the block returns to IDLE.
- Outside RUN, cmp_a and cmp_b are 0.
- in_valid is ignored outside IDLE; a_word and b_word need not be held after the accept.
- Result outputs hold their last value while the block is in IDLE. They change only while the block is in RUN.
- mismatch_cnt under EARLY_EXIT=1 is at most 1.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, cmp_a=0, cmp_b=0, eq=1, mismatch_idx=0, mismatch_cnt=0. The internal idx and operand registers are also cleared.
- Accept at edge T0. RUN covers the cycles after edges T0..T0+WIDTH-1, one bit per cycle.
- out_valid rises after edge T0+WIDTH, i.e. latency is WIDTH cycles from accept to result.
- With EARLY_EXIT=1 and the first mismatch at bit k, out_valid rises after edge T0+k+1.
- Result handoff at edge Tr (out_valid && out_ready):
  - in_ready rises after Tr.
  - There is no same-cycle turnaround, so the minimum spacing between accepts is WIDTH+2 cycles.
- out_ready low in DONE: the block stalls indefinitely and the outputs do not change.
- out_ready high outside DONE: no effect.
- rst asserted at any point, including mid-RUN, returns the block to IDLE with the reset values immediately, without waiting for a clock edge. The partial result is discarded and no out_valid is produced.
- Idx wrap: idx never exceeds WIDTH-1, because RUN exits on the last bit.

## Test plan
- WIDTH=8, EARLY_EXIT=0, accept A=0xA5, B=0xA5 with out_ready=1 → out_valid exactly 8 cycles after accept; eq=1, mismatch_idx=0, mismatch_cnt=0; in_ready returns one cycle later.
- WIDTH=8, A=0x80, B=0x00 → eq=0, mismatch_idx=7, mismatch_cnt=1. Second transaction A=0xF0, B=0x0F → eq=0, mismatch_idx=0, mismatch_cnt=8.
- WIDTH=8, EARLY_EXIT=1, A=0x00, B=0x04 → out_valid 3 cycles after accept; eq=0, mismatch_idx=2, mismatch_cnt=1. The cmp_a/cmp_b trace shows bits 0, 1, 2 only.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new words → outputs stable, in_ready=0, new words not captured. Raise out_ready → IDLE next cycle, and the pending words are accepted the following edge.
- Assert rst for 1 cycle at RUN bit 4 of A=0x00, B=0xFF → all outputs take their reset values immediately and no out_valid is seen. A fresh A=0x3C, B=0x3C → eq=1 after 8 cycles.
- Cell check: force cmp_eq=0 for one RUN cycle at bit 5 while the operands are equal → eq=0, mismatch_idx=5, mismatch_cnt=1, proving the block uses the external cell rather than an internal compare.
